// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for a small accumulator machine.
// Sequences FETCH/DECODE/EXEC, raises datapath strobes combinationally and
// guards every memory wait with a timeout that parks the machine in HALT.
// Optional feature: define MCCTRL_INSTR_CNT_EN to add the instr_cnt output
// (retired-instruction counter, wraps modulo 2^CNT_W).
module multicycle_controller #(
   parameter int DATA_W      = 16,
   parameter int TMO_W       = 8,
   parameter int MEM_TIMEOUT = 200,
   parameter int CNT_W       = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        opcode,
   input  logic [DATA_W-1:0] ac,
   input  logic              mem_ack,
   output logic              rd_mem,
   output logic              wr_mem,
   output logic              addr_sel,
   output logic              ld_ir,
   output logic              ld_pc,
   output logic              pc_src,
   output logic              ac_src,
   output logic              ld_ac,
   output logic              ld_imm,
   output logic              alu_add,
   output logic              alu_sub,
   output logic              halted,
   output logic              mem_err,
`ifdef MCCTRL_INSTR_CNT_EN
   output logic [CNT_W-1:0]  instr_cnt,
`endif
   output logic [2:0]        state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   localparam logic [2:0] OP_LDA = 3'b000;
   localparam logic [2:0] OP_STA = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_JMP = 3'b100;
   localparam logic [2:0] OP_JEZ = 3'b101;
   localparam logic [2:0] OP_LDI = 3'b110;
   localparam logic [2:0] OP_HLT = 3'b111;

   state_t           r_state;
   state_t           w_next;
   logic [TMO_W-1:0] r_tmo;
   logic             r_mem_err;
   logic             w_wait;
   logic             w_tmo_hit;
   logic             w_retire;

   logic w_rd, w_wr, w_addr_sel, w_ld_ir, w_ld_pc, w_pc_src;
   logic w_ac_src, w_ld_ac, w_ld_imm, w_add, w_sub, w_halted;

   // Memory waits: FETCH and the EXEC of the four memory opcodes (opcode[2]==0).
   assign w_wait    = (r_state == S_FETCH) || ((r_state == S_EXEC) && !opcode[2]);
   // Ack wins over an expiring timer, so the hit requires no ack this cycle.
   assign w_tmo_hit = (MEM_TIMEOUT != 0) && w_wait && !mem_ack &&
                      (r_tmo == TMO_W'(MEM_TIMEOUT - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state and strobe decode from state, opcode, ac and mem_ack.
   always_comb begin
      w_next     = r_state;
      w_rd       = 1'b0;
      w_wr       = 1'b0;
      w_addr_sel = 1'b0;
      w_ld_ir    = 1'b0;
      w_ld_pc    = 1'b0;
      w_pc_src   = 1'b0;
      w_ac_src   = 1'b0;
      w_ld_ac    = 1'b0;
      w_ld_imm   = 1'b0;
      w_add      = 1'b0;
      w_sub      = 1'b0;
      w_halted   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_next = S_FETCH;
         end
         S_FETCH: begin
            w_rd = !w_tmo_hit;
            if (mem_ack) begin
               w_ld_ir = 1'b1;
               w_next  = S_DECODE;
            end else if (w_tmo_hit) begin
               w_next = S_HALT;
            end
         end
         S_DECODE: begin
            if (opcode == OP_HLT) begin
               w_next = S_HALT;
            end else begin
               w_ld_pc = 1'b1;
               w_next  = S_EXEC;
            end
         end
         S_EXEC: begin
            case (opcode)
               OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
                  w_addr_sel = 1'b1;
                  w_rd       = !w_tmo_hit && (opcode != OP_STA);
                  w_wr       = !w_tmo_hit && (opcode == OP_STA);
                  if (mem_ack) begin
                     w_ac_src = (opcode == OP_LDA);
                     w_add    = (opcode == OP_ADD);
                     w_sub    = (opcode == OP_SUB);
                     w_ld_ac  = (opcode != OP_STA);
                     w_next   = S_FETCH;
                  end else if (w_tmo_hit) begin
                     w_next = S_HALT;
                  end
               end
               OP_JMP: begin
                  w_ld_pc  = 1'b1;
                  w_pc_src = 1'b1;
                  w_next   = S_FETCH;
               end
               OP_JEZ: begin
                  w_ld_pc  = (ac == '0);
                  w_pc_src = (ac == '0);
                  w_next   = S_FETCH;
               end
               OP_LDI: begin
                  w_ld_imm = 1'b1;
                  w_ld_ac  = 1'b1;
                  w_next   = S_FETCH;
               end
               default: w_next = S_FETCH; // HLT never reaches EXEC
            endcase
         end
         S_HALT: begin
            w_halted = 1'b1;
            if (start) w_next = S_FETCH;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Instruction retires on EXEC->FETCH and on DECODE->HALT (HLT).
   assign w_retire = ((r_state == S_EXEC) && (w_next == S_FETCH)) ||
                     ((r_state == S_DECODE) && (w_next == S_HALT));

   // Wait-cycle counter: counts unacked wait cycles, zero outside a wait.
   always_ff @(posedge clk) begin
      if (reset)                               r_tmo <= '0;
      else if (w_wait && !mem_ack && !w_tmo_hit) r_tmo <= r_tmo + 1'b1;
      else                                     r_tmo <= '0;
   end

   // Sticky timeout flag, cleared when start resumes from HALT.
   always_ff @(posedge clk) begin
      if (reset)                             r_mem_err <= 1'b0;
      else if (w_tmo_hit)                    r_mem_err <= 1'b1;
      else if ((r_state == S_HALT) && start) r_mem_err <= 1'b0;
   end

`ifdef MCCTRL_INSTR_CNT_EN
   logic [CNT_W-1:0] r_icnt;

   // Retired-instruction counter, wraps naturally.
   always_ff @(posedge clk) begin
      if (reset)         r_icnt <= '0;
      else if (w_retire) r_icnt <= r_icnt + 1'b1;
   end

   assign instr_cnt = reset ? '0 : r_icnt;
`else
   logic w_unused_retire;
   assign w_unused_retire = w_retire;
`endif

   // Outputs are forced low while reset is asserted, even before the edge.
   assign rd_mem   = w_rd       & ~reset;
   assign wr_mem   = w_wr       & ~reset;
   assign addr_sel = w_addr_sel & ~reset;
   assign ld_ir    = w_ld_ir    & ~reset;
   assign ld_pc    = w_ld_pc    & ~reset;
   assign pc_src   = w_pc_src   & ~reset;
   assign ac_src   = w_ac_src   & ~reset;
   assign ld_ac    = w_ld_ac    & ~reset;
   assign ld_imm   = w_ld_imm   & ~reset;
   assign alu_add  = w_add      & ~reset;
   assign alu_sub  = w_sub      & ~reset;
   assign halted   = w_halted   & ~reset;
   assign mem_err  = r_mem_err  & ~reset;
   assign state    = reset ? 3'd0 : r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a stimulus process drives one
// cycle at a time and pushes the model's expected outputs; a monitor pops and
// compares shortly after each falling edge.
module tb_multicycle_controller;
   localparam int DW  = 16;
   localparam int TMO = 4;
   localparam int CW  = 2;

   logic          clk = 1'b0;
   logic          reset, start, mem_ack;
   logic [2:0]    opcode;
   logic [DW-1:0] ac;
   logic rd_mem, wr_mem, addr_sel, ld_ir, ld_pc, pc_src, ac_src, ld_ac;
   logic ld_imm, alu_add, alu_sub, halted, mem_err;
   logic [2:0]    state;
`ifdef MCCTRL_INSTR_CNT_EN
   logic [CW-1:0] instr_cnt;
`endif

   always #5 clk = ~clk;

   multicycle_controller #(.DATA_W(DW), .TMO_W(8), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .opcode(opcode), .ac(ac),
      .mem_ack(mem_ack), .rd_mem(rd_mem), .wr_mem(wr_mem), .addr_sel(addr_sel),
      .ld_ir(ld_ir), .ld_pc(ld_pc), .pc_src(pc_src), .ac_src(ac_src),
      .ld_ac(ld_ac), .ld_imm(ld_imm), .alu_add(alu_add), .alu_sub(alu_sub),
      .halted(halted), .mem_err(mem_err),
`ifdef MCCTRL_INSTR_CNT_EN
      .instr_cnt(instr_cnt),
`endif
      .state(state));

   // Expected strobe vector order:
   // {rd,wr,addr_sel,ld_ir,ld_pc,pc_src,ac_src,ld_ac,ld_imm,add,sub,halted,mem_err}
   typedef struct {
      int          cyc;
      logic [2:0]  st;
      logic [12:0] strb;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int cyc_no = 0;

   // Reference model: machine phase (spec numbering), cycles spent waiting,
   // sticky error, retired count.
   int          m_st   = 0;
   int          m_wait = 0;
   bit          m_err  = 0;
   int          m_cnt  = 0;
   logic [2:0]  m_op   = 3'd0;

   task automatic c(input bit rs, input bit st, input logic [2:0] op,
                    input logic [DW-1:0] a, input bit ak);
      exp_t e;
      bit rd = 0, wr = 0, as = 0, lir = 0, lpc = 0, psrc = 0, acs = 0, lac = 0;
      bit limm = 0, add = 0, sub = 0, hl = 0;
      bit mem_op, done, expire;
      int nxt;
      @(negedge clk);
      reset = rs; start = st; opcode = op; ac = a; mem_ack = ak;
      cyc_no++;
      e.cyc = cyc_no;
      e.st  = rs ? 3'd0 : 3'(m_st);
      e.cnt = rs ? '0 : CW'(m_cnt);
      nxt = m_st;
      if (rs) begin
         e.strb = '0;
         m_st = 0; m_wait = 0; m_err = 0; m_cnt = 0;
      end else begin
         mem_op = (m_st == 1) || (m_st == 3 && op < 3'd4);
         if (mem_op) begin
            done   = ak;
            expire = !ak && (TMO != 0) && (m_wait + 1 == TMO);
            as = (m_st == 3);
            if (!expire) begin
               if (m_st == 3 && op == 3'd1) wr = 1; else rd = 1;
            end
            if (done) begin
               if (m_st == 1) begin lir = 1; nxt = 2; end
               else begin
                  nxt = 1; m_cnt++;
                  if (op == 3'd0) begin acs = 1; lac = 1; end
                  if (op == 3'd2) begin add = 1; lac = 1; end
                  if (op == 3'd3) begin sub = 1; lac = 1; end
               end
               m_wait = 0;
            end else if (expire) begin
               nxt = 4; m_wait = 0;
            end else m_wait++;
         end else begin
            m_wait = 0;
            expire = 0;
            case (m_st)
               0: if (st) nxt = 1;
               2: if (op == 3'd7) begin nxt = 4; m_cnt++; end
                  else begin lpc = 1; nxt = 3; end
               3: begin
                  nxt = 1; m_cnt++;
                  if (op == 3'd4) begin lpc = 1; psrc = 1; end
                  if (op == 3'd5 && a == 0) begin lpc = 1; psrc = 1; end
                  if (op == 3'd6) begin limm = 1; lac = 1; end
               end
               4: begin hl = 1; if (st) nxt = 1; end
               default: nxt = 0;
            endcase
         end
         e.strb = {rd, wr, as, lir, lpc, psrc, acs, lac, limm, add, sub, hl, m_err};
         if (expire) m_err = 1;
         else if (m_st == 4 && st) m_err = 0;
         m_st = nxt;
      end
      q.push_back(e);
   endtask

   // Monitor: compare whatever the stimulus has queued for this cycle.
   initial begin
      exp_t e;
      logic [12:0] got;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            got = {rd_mem, wr_mem, addr_sel, ld_ir, ld_pc, pc_src, ac_src, ld_ac,
                   ld_imm, alu_add, alu_sub, halted, mem_err};
            n_cmp++;
            if (state !== e.st) begin
               n_bad++;
               $display("FAIL state cyc%0d: got %0d want %0d", e.cyc, state, e.st);
            end
            n_cmp++;
            if (got !== e.strb) begin
               n_bad++;
               $display("FAIL strobes cyc%0d: got %b want %b", e.cyc, got, e.strb);
            end
`ifdef MCCTRL_INSTR_CNT_EN
            n_cmp++;
            if (instr_cnt !== e.cnt) begin
               n_bad++;
               $display("FAIL instr_cnt cyc%0d: got %0d want %0d", e.cyc, instr_cnt, e.cnt);
            end
`endif
         end
      end
   end

   // Fetch an instruction with an immediate ack, then decode it.
   task automatic fd(input logic [2:0] op);
      c(0, 0, op, 16'h0, 1);
      c(0, 0, op, 16'h0, 0);
   endtask

   initial begin
      logic [2:0] rop;
      logic [DW-1:0] rac;
      reset = 1; start = 0; opcode = 0; ac = 0; mem_ack = 0;
      // reset and idle
      c(1, 1, 3'd0, 16'h0, 1);
      c(1, 0, 3'd0, 16'h0, 0);
      c(0, 0, 3'd0, 16'h0, 1);
      // LDA, memory ack on the third EXEC cycle
      c(0, 1, 3'd0, 16'h0, 0);
      c(0, 0, 3'd0, 16'h0, 0);
      c(0, 0, 3'd0, 16'h0, 1);
      c(0, 0, 3'd0, 16'h0, 0);
      c(0, 0, 3'd0, 16'h0, 0);
      c(0, 0, 3'd0, 16'h0, 0);
      c(0, 0, 3'd0, 16'h0, 1);
      // JEZ taken / not taken, JMP, STA, ADD, SUB
      fd(3'd5); c(0, 0, 3'd5, 16'h0000, 0);
      fd(3'd5); c(0, 0, 3'd5, 16'h0001, 0);
      fd(3'd4); c(0, 0, 3'd4, 16'h1234, 0);
      fd(3'd1); c(0, 1, 3'd1, 16'h0, 0); c(0, 0, 3'd1, 16'h0, 1);
      fd(3'd2); c(0, 0, 3'd2, 16'h0, 1);
      fd(3'd3); c(0, 0, 3'd3, 16'h0, 1);
      // five LDIs (counter wraps at CW=2)
      repeat (5) begin fd(3'd6); c(0, 0, 3'd6, 16'h0, 0); end
      // HLT, idle in HALT, resume
      fd(3'd7); c(0, 0, 3'd7, 16'h0, 1); c(0, 1, 3'd7, 16'h0, 0);
      // FETCH timeout, resume clears mem_err
      repeat (4) c(0, 0, 3'd0, 16'h0, 0);
      c(0, 0, 3'd0, 16'h0, 0);
      c(0, 1, 3'd0, 16'h0, 0);
      // ack coincides with the would-be timeout cycle
      repeat (3) c(0, 0, 3'd0, 16'h0, 0);
      c(0, 0, 3'd0, 16'h0, 1);
      c(0, 0, 3'd0, 16'h0, 0);
      // EXEC timeout on STA
      repeat (4) c(0, 0, 3'd1, 16'h0, 0);
      c(0, 1, 3'd1, 16'h0, 0);
      // reset in EXEC coincident with ack
      fd(3'd0); c(1, 0, 3'd0, 16'h0, 1); c(0, 0, 3'd0, 16'h0, 0);
      // randomized traffic; opcode only changes where the IR is not in use
      rop = 3'd0;
      repeat (3000) begin
         if (m_st == 0 || m_st == 1 || m_st == 4) rop = 3'($urandom_range(0, 7));
         rac = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
         c($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 3, rop, rac,
           $urandom_range(0, 99) < 35);
      end
      c(0, 0, rop, 16'h0, 0);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d left want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: DATA_W, 16, accumulator width examined for the JEZ zero test.
REQ-002 Parameter: TMO_W, 8, width of the memory-wait timeout counter.
REQ-003 Parameter: MEM_TIMEOUT, 200, maximum wait cycles for mem_ack; 0 disables the timeout.
REQ-004 Parameter: CNT_W, 32, instruction-counter width.
REQ-005 clk  in  1  sole clock; all state changes on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  begin or resume fetching; sampled in IDLE and HALT only.
REQ-008 opcode  in  3  instruction-register opcode field, stable from DECODE through EXEC.
REQ-009 ac  in  DATA_W  accumulator value.
REQ-010 mem_ack  in  1  memory completion, one cycle wide.
REQ-011 rd_mem, wr_mem  out  1 each  memory read/write request, held until mem_ack.
REQ-012 addr_sel  out  1  memory address select: 0 = PC, 1 = IR operand.
REQ-013 ld_ir, ld_pc, pc_src  out  1 each  IR load; PC load; PC source (0 = PC+1, 1 = operand).
REQ-014 ac_src, ld_ac, ld_imm, alu_add, alu_sub  out  1 each  datapath strobes.
REQ-015 halted, mem_err  out  1 each  in HALT; sticky memory-timeout flag.
REQ-016 state  out  3  current state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, HALT=4.

Function
REQ-017 The state register SHALL be the only state storage apart from the timeout counter, mem_err and the optional instruction counter; strobes SHALL decode combinationally from state, opcode, ac and mem_ack.
REQ-018 IDLE: all strobes 0; start=1 -> FETCH.
REQ-019 FETCH: rd_mem=1, addr_sel=0; on mem_ack, ld_ir=1 that cycle -> DECODE.
REQ-020 DECODE: one cycle, ld_pc=1, pc_src=0; opcode 111 (HLT) -> HALT with no PC load; otherwise -> EXEC.
REQ-021 EXEC, LDA(000): rd_mem=1, addr_sel=1; on mem_ack, ac_src=1 and ld_ac=1 -> FETCH.
REQ-022 EXEC, STA(001): wr_mem=1, addr_sel=1; on mem_ack -> FETCH.
REQ-023 EXEC, ADD(010)/SUB(011): rd_mem=1, addr_sel=1; on mem_ack, alu_add or alu_sub=1 and ld_ac=1 -> FETCH.
REQ-024 EXEC, JMP(100): ld_pc=1, pc_src=1 for one cycle -> FETCH.
REQ-025 EXEC, JEZ(101): ld_pc=1, pc_src=1 only if all DATA_W bits of ac are 0; one cycle -> FETCH.
REQ-026 EXEC, LDI(110): ld_imm=1, ld_ac=1 for one cycle -> FETCH.
REQ-027 HALT: halted=1, all strobes 0; start=1 -> FETCH, clearing mem_err; PC is not reloaded.
REQ-028 The timeout counter SHALL clear on entry to any memory wait and increment each wait cycle without mem_ack; on reaching MEM_TIMEOUT (nonzero), the block SHALL go to HALT, set mem_err=1 and drop the request that cycle.
REQ-029 mem_ack and timeout in the same cycle: mem_ack wins.
REQ-030 start outside IDLE/HALT SHALL be ignored; mem_ack outside a wait SHALL be ignored.

Reset
REQ-031 reset=1 SHALL force state=IDLE, mem_err=0, timeout counter=0 and the instruction counter=0 at the next edge, overriding start, mem_ack and timeout in any state.
REQ-032 During and directly after reset, every output SHALL be 0 except state=0.

Configuration
REQ-033 Macro MCCTRL_INSTR_CNT_EN defined: output instr_cnt [CNT_W] SHALL increment by one on each EXEC exit to FETCH and each DECODE->HALT, wrapping modulo 2^CNT_W.
REQ-034 Macro MCCTRL_INSTR_CNT_EN undefined: the instr_cnt port and its counter SHALL not exist; all other behaviour is identical.

Verification
REQ-035 Reset, start pulse, LDA with ack after 3 cycles -> states 0,1..1,2,3..3,1; ld_ac and ac_src are high exactly in the ack cycle.
REQ-036 JEZ with ac=0 -> pc_src=1, ld_pc=1 for one EXEC cycle; JEZ with ac=0x0001 -> no PC load in EXEC.
REQ-037 HLT opcode -> DECODE then HALT, halted=1, no ld_pc; start=1 -> FETCH next cycle.
REQ-038 MEM_TIMEOUT=4 with mem_ack held low in FETCH -> HALT after 4 wait cycles, mem_err=1; start clears mem_err.
REQ-039 reset asserted in EXEC coincident with mem_ack -> IDLE next cycle, no ld_ac, all outputs 0.
REQ-040 With MCCTRL_INSTR_CNT_EN and CNT_W=2: 5 LDI instructions -> instr_cnt sequence 1,2,3,0,1.
